// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N counter and its prescaler.
package counter_pkg;

  typedef enum logic {DIR_DOWN, DIR_UP} dir_t;

  // Register width for a counter that must hold 0..x-1, never narrower than one bit.
  function automatic int clog2_min1(input int x);
    return ($clog2(x) < 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/prescaler.sv
// Divides enabled clock cycles by PRESCALE and emits a one-cycle tick on the last one.
module prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = clog2_min1(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] pcount;

  // With PRESCALE=1 the register is pinned at 0 and tick degenerates to enable.
  assign tick = enable && (pcount == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcount <= '0;
    end else if (clear) begin
      pcount <= '0;
    end else if (enable) begin
      pcount <= tick ? '0 : pcount + W'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with prescaler, synchronous clear/load, wrap or saturate, wrap pulse.
module mod_counter
  import counter_pkg::*;
#(
  parameter int     N        = 8,
  parameter longint MODULUS  = longint'(1) << N,
  parameter int     PRESCALE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         saturate,
  output logic [N-1:0] cnt,
  output logic         wrap,
  output logic         at_limit
);

  if (N < 1 || N > 32) begin : g_bad_width
    $error("mod_counter: N=%0d outside 1..32", N);
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << N)) begin : g_bad_modulus
    $error("mod_counter: MODULUS=%0d outside 2..2**N", MODULUS);
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
    $error("mod_counter: PRESCALE=%0d outside 1..65536", PRESCALE);
  end

  // Top of range kept N+1 bits wide so MODULUS=2**N compares without overflow.
  localparam longint       LAST_L = MODULUS - 1;
  localparam logic [N:0]   LAST   = LAST_L[N:0];

  logic         tick;
  logic [N:0]   cnt_ext;
  logic [N:0]   load_ext;
  logic [N-1:0] load_clamped;
  logic [N-1:0] cnt_nxt;
  logic         wrap_nxt;
  dir_t         dir;

  prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear | load),
    .enable (enable),
    .tick   (tick)
  );

  assign dir          = dir_t'(up);
  assign cnt_ext      = {1'b0, cnt};
  assign load_ext     = {1'b0, load_value};
  assign load_clamped = (load_ext > LAST) ? LAST[N-1:0] : load_value;
  assign at_limit     = (dir == DIR_UP) ? (cnt_ext == LAST) : (cnt == '0);

  // Priority: clear, then load, then a step on tick; saturated holds never pulse wrap.
  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (clear) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = load_clamped;
    end else if (tick) begin
      case (dir)
        DIR_UP: begin
          if (cnt_ext < LAST) begin
            cnt_nxt = cnt + N'(1);
          end else if (!saturate) begin
            cnt_nxt  = '0;
            wrap_nxt = 1'b1;
          end
        end
        DIR_DOWN: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - N'(1);
          end else if (!saturate) begin
            cnt_nxt  = LAST[N-1:0];
            wrap_nxt = 1'b1;
          end
        end
        default: begin
          cnt_nxt = cnt;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: mod-10 table, prescale-3 sequence, legacy mod-4 sequence.
module tb_mod_counter;

  logic clock;
  logic reset;

  logic       a_clear, a_load, a_en, a_up, a_sat;
  logic [3:0] a_lv, a_cnt;
  logic       a_wrap, a_al;

  logic       p_clear, p_load, p_en, p_up, p_sat;
  logic [3:0] p_lv, p_cnt;
  logic       p_wrap, p_al;

  logic       l_clear, l_load, l_en, l_up, l_sat;
  logic [1:0] l_lv, l_cnt;
  logic       l_wrap, l_al;

  int checks   = 0;
  int failures = 0;

  mod_counter #(.N(4), .MODULUS(10), .PRESCALE(1)) dut_a (
    .clock(clock), .reset(reset), .clear(a_clear), .enable(a_en), .up(a_up),
    .load(a_load), .load_value(a_lv), .saturate(a_sat),
    .cnt(a_cnt), .wrap(a_wrap), .at_limit(a_al)
  );

  mod_counter #(.N(4), .MODULUS(10), .PRESCALE(3)) dut_p (
    .clock(clock), .reset(reset), .clear(p_clear), .enable(p_en), .up(p_up),
    .load(p_load), .load_value(p_lv), .saturate(p_sat),
    .cnt(p_cnt), .wrap(p_wrap), .at_limit(p_al)
  );

  mod_counter #(.N(2), .MODULUS(4), .PRESCALE(1)) dut_l (
    .clock(clock), .reset(reset), .clear(l_clear), .enable(l_en), .up(l_up),
    .load(l_load), .load_value(l_lv), .saturate(l_sat),
    .cnt(l_cnt), .wrap(l_wrap), .at_limit(l_al)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       clr, ld;
    logic [3:0] lv;
    logic       en, up, sat;
    logic [3:0] cnt;
    logic       wrap, al;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic clr, ld, input logic [3:0] lv,
                              input logic en, up, sat,
                              input logic [3:0] cnt, input logic wrap, al);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.up = up; v.sat = sat;
    v.cnt = cnt; v.wrap = wrap; v.al = al;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_p(input logic en, ld, input logic [3:0] lv, input logic [3:0] exp_cnt,
                        input int idx);
    p_en = en; p_load = ld; p_lv = lv;
    @(negedge clock);
    check($sformatf("p_cnt[%0d]", idx), 32'(p_cnt), 32'(exp_cnt));
  endtask

  initial begin
    reset = 1'b1;
    {a_clear, a_load, a_en, a_up, a_sat} = '0; a_lv = '0;
    {p_clear, p_load, p_en, p_sat} = '0; p_up = 1'b1; p_lv = '0;
    {l_clear, l_load, l_en, l_sat} = '0; l_up = 1'b1; l_lv = '0;

    // Mod-10 table: count up through wrap, loads, saturate, down wrap, clear priority.
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0, 0, 0, 1, 1, 0, 4'(i), 0, i == 9));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1,  7, 1, 1, 0, 7, 0, 0));
    tbl.push_back(mk(0, 1, 15, 1, 1, 0, 9, 0, 1));
    tbl.push_back(mk(0, 0,  0, 1, 1, 1, 9, 0, 1));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0, 8, 0, 0));
    tbl.push_back(mk(1, 0,  0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0, 9, 1, 0));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0, 8, 0, 0));
    tbl.push_back(mk(1, 1,  5, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  6, 0, 1, 0, 6, 0, 0));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0, 7, 0, 0));

    @(negedge clock);
    check("reset_a_cnt", 32'(a_cnt), 0);
    check("reset_a_wrap", 32'(a_wrap), 0);
    check("reset_a_at_limit_down", 32'(a_al), 1);
    check("reset_p_cnt", 32'(p_cnt), 0);
    check("reset_l_cnt", 32'(l_cnt), 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      a_clear = tbl[i].clr; a_load = tbl[i].ld; a_lv = tbl[i].lv;
      a_en = tbl[i].en; a_up = tbl[i].up; a_sat = tbl[i].sat;
      @(negedge clock);
      check($sformatf("a_cnt[%0d]", i), 32'(a_cnt), 32'(tbl[i].cnt));
      check($sformatf("a_wrap[%0d]", i), 32'(a_wrap), 32'(tbl[i].wrap));
      check($sformatf("a_at_limit[%0d]", i), 32'(a_al), 32'(tbl[i].al));
    end

    // Asynchronous reset mid-cycle: cnt clears with no clock edge.
    #2 reset = 1'b1;
    #1 check("async_a_cnt", 32'(a_cnt), 0);
    check("async_a_wrap", 32'(a_wrap), 0);
    @(negedge clock);
    reset = 1'b0;
    a_en = 1'b0;

    // Prescale 3: a step every third enabled edge; two disabled cycles delay it by two.
    step_p(1, 0, 0, 0, 1);
    step_p(1, 0, 0, 0, 2);
    step_p(1, 0, 0, 1, 3);
    step_p(1, 0, 0, 1, 4);
    step_p(1, 0, 0, 1, 5);
    step_p(1, 0, 0, 2, 6);
    step_p(1, 0, 0, 2, 7);
    step_p(0, 0, 0, 2, 8);
    step_p(0, 0, 0, 2, 9);
    step_p(1, 0, 0, 2, 10);
    step_p(1, 0, 0, 3, 11);
    step_p(1, 0, 0, 3, 12);
    step_p(1, 0, 0, 3, 13);
    step_p(1, 1, 7, 7, 14);
    step_p(1, 0, 0, 7, 15);
    step_p(1, 0, 0, 7, 16);
    step_p(1, 0, 0, 8, 17);
    step_p(1, 0, 0, 8, 18);

    // Reset with the prescaler part-way: it must restart and count three edges again.
    #2 reset = 1'b1;
    #1 check("async_p_cnt", 32'(p_cnt), 0);
    @(negedge clock);
    reset = 1'b0;
    step_p(1, 0, 0, 0, 19);
    step_p(1, 0, 0, 0, 20);
    step_p(1, 0, 0, 1, 21);
    p_en = 1'b0;

    // Legacy 2-bit configuration behaves as a free-running binary counter.
    check("l_cnt_start", 32'(l_cnt), 0);
    l_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      check($sformatf("l_cnt[%0d]", i), 32'(l_cnt), 32'(i % 4));
      check($sformatf("l_wrap[%0d]", i), 32'(l_wrap), 32'(i == 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
